axi_counter_cfg_arbiter: RTL and testbench

Two-port register-access arbiter that shares the single AXI4-Lite slave port of `custom_axi_counter` between two on-chip requesters. Each client issues simple level-held read or write requests to one of the counter's four 32-bit registers. The block arbitrates between the clients, sequences the full AXI4-Lite handshake on the master side, and returns read data and response to the winning client. It sits between the control logic and the counter IP's `S00_AXI` port.

---
 rtl/axi_counter_cfg_arbiter.sv | 178 +++++++++++++++++
 tb/tb_axi_counter_cfg_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_counter_cfg_arbiter.sv
// Two-client arbiter sharing one AXI4-Lite master port into the counter register block.
// Define CNTR_ARB_RR_EN for round-robin arbitration; otherwise client 0 has fixed priority.
module axi_counter_cfg_arbiter #(
  parameter int C_ADDR_WIDTH = 4,
  parameter int C_DATA_WIDTH = 32
) (
  input  logic                      ACLK,
  input  logic                      ARESET,
  input  logic                      c0_req,
  input  logic                      c0_we,
  input  logic [C_ADDR_WIDTH-1:0]   c0_addr,
  input  logic [C_DATA_WIDTH-1:0]   c0_wdata,
  output logic                      c0_done,
  input  logic                      c1_req,
  input  logic                      c1_we,
  input  logic [C_ADDR_WIDTH-1:0]   c1_addr,
  input  logic [C_DATA_WIDTH-1:0]   c1_wdata,
  output logic                      c1_done,
  output logic [C_DATA_WIDTH-1:0]   rdata,
  output logic [1:0]                resp,
  output logic                      busy,
  output logic [2:0]                dbg_state,
  output logic [C_ADDR_WIDTH-1:0]   m_awaddr,
  output logic [2:0]                m_awprot,
  output logic                      m_awvalid,
  input  logic                      m_awready,
  output logic [C_DATA_WIDTH-1:0]   m_wdata,
  output logic [C_DATA_WIDTH/8-1:0] m_wstrb,
  output logic                      m_wvalid,
  input  logic                      m_wready,
  input  logic [1:0]                m_bresp,
  input  logic                      m_bvalid,
  output logic                      m_bready,
  output logic [C_ADDR_WIDTH-1:0]   m_araddr,
  output logic [2:0]                m_arprot,
  output logic                      m_arvalid,
  input  logic                      m_arready,
  input  logic [C_DATA_WIDTH-1:0]   m_rdata,
  input  logic [1:0]                m_rresp,
  input  logic                      m_rvalid,
  output logic                      m_rready
);

  // Handshake rule on every AXI channel: a transfer happens on the rising edge where
  // valid and ready are both high; a raised valid holds, with stable payload, until then.
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR      = 3'd1,
    S_WR_RESP = 3'd2,
    S_RD      = 3'd3,
    S_RD_DATA = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  localparam logic [C_ADDR_WIDTH-1:0] ADDR_MASK = {{(C_ADDR_WIDTH-2){1'b1}}, 2'b00};

  state_t                  state;
  logic                    gnt;
  logic                    pick;
  logic                    sel_we;
  logic [C_ADDR_WIDTH-1:0] sel_addr;
  logic [C_DATA_WIDTH-1:0] sel_wdata;

  assign dbg_state = state;
  assign m_awprot  = 3'b000;
  assign m_arprot  = 3'b000;
  assign m_wstrb   = '1;

`ifdef CNTR_ARB_RR_EN
  logic last_gnt;

  always_comb begin
    pick = 1'b0;
    if (c0_req && c1_req) pick = ~last_gnt;
    else if (!c0_req)     pick = 1'b1;
  end
`else
  // pick only matters when some request is present, so c0 idle means c1 wins.
  always_comb begin
    pick = ~c0_req;
  end
`endif

  always_comb begin
    sel_we    = pick ? c1_we    : c0_we;
    sel_addr  = pick ? c1_addr  : c0_addr;
    sel_wdata = pick ? c1_wdata : c0_wdata;
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state     <= S_IDLE;
      gnt       <= 1'b0;
`ifdef CNTR_ARB_RR_EN
      last_gnt  <= 1'b1;
`endif
      m_awaddr  <= '0;
      m_araddr  <= '0;
      m_wdata   <= '0;
      m_awvalid <= 1'b0;
      m_wvalid  <= 1'b0;
      m_bready  <= 1'b0;
      m_arvalid <= 1'b0;
      m_rready  <= 1'b0;
      c0_done   <= 1'b0;
      c1_done   <= 1'b0;
      rdata     <= '0;
      resp      <= 2'b00;
      busy      <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (c0_req || c1_req) begin
            gnt      <= pick;
`ifdef CNTR_ARB_RR_EN
            last_gnt <= pick;
`endif
            m_awaddr <= sel_addr & ADDR_MASK;
            m_araddr <= sel_addr & ADDR_MASK;
            m_wdata  <= sel_wdata;
            busy     <= 1'b1;
            if (sel_we) begin
              m_awvalid <= 1'b1;
              m_wvalid  <= 1'b1;
              state     <= S_WR;
            end else begin
              m_arvalid <= 1'b1;
              state     <= S_RD;
            end
          end
        end
        S_WR: begin
          // AW and W complete independently; leave only once neither is outstanding.
          if (m_awvalid && m_awready) m_awvalid <= 1'b0;
          if (m_wvalid && m_wready)   m_wvalid  <= 1'b0;
          if ((!m_awvalid || m_awready) && (!m_wvalid || m_wready)) begin
            m_bready <= 1'b1;
            state    <= S_WR_RESP;
          end
        end
        S_WR_RESP: begin
          if (m_bvalid) begin
            resp     <= m_bresp;
            m_bready <= 1'b0;
            c0_done  <= ~gnt;
            c1_done  <= gnt;
            state    <= S_DONE;
          end
        end
        S_RD: begin
          if (m_arready) begin
            m_arvalid <= 1'b0;
            m_rready  <= 1'b1;
            state     <= S_RD_DATA;
          end
        end
        S_RD_DATA: begin
          if (m_rvalid) begin
            rdata    <= m_rdata;
            resp     <= m_rresp;
            m_rready <= 1'b0;
            c0_done  <= ~gnt;
            c1_done  <= gnt;
            state    <= S_DONE;
          end
        end
        S_DONE: begin
          c0_done <= 1'b0;
          c1_done <= 1'b0;
          busy    <= 1'b0;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_counter_cfg_arbiter.sv
// Directed bench for axi_counter_cfg_arbiter with a small AXI4-Lite register slave model.
// Grant-order expectations follow CNTR_ARB_RR_EN when it is defined for the build.
module tb_axi_counter_cfg_arbiter;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic        c0_req, c0_we, c1_req, c1_we;
  logic [3:0]  c0_addr, c1_addr;
  logic [31:0] c0_wdata, c1_wdata;
  logic        c0_done, c1_done;
  logic [31:0] rdata;
  logic [1:0]  resp;
  logic        busy;
  logic [2:0]  dbg_state;
  logic [3:0]  m_awaddr, m_araddr;
  logic [2:0]  m_awprot, m_arprot;
  logic        m_awvalid, m_awready, m_wvalid, m_wready;
  logic [31:0] m_wdata, m_rdata;
  logic [3:0]  m_wstrb;
  logic [1:0]  m_bresp, m_rresp;
  logic        m_bvalid, m_bready, m_arvalid, m_arready, m_rvalid, m_rready;

  axi_counter_cfg_arbiter dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .c0_req(c0_req), .c0_we(c0_we), .c0_addr(c0_addr), .c0_wdata(c0_wdata), .c0_done(c0_done),
    .c1_req(c1_req), .c1_we(c1_we), .c1_addr(c1_addr), .c1_wdata(c1_wdata), .c1_done(c1_done),
    .rdata(rdata), .resp(resp), .busy(busy), .dbg_state(dbg_state),
    .m_awaddr(m_awaddr), .m_awprot(m_awprot), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_araddr(m_araddr), .m_arprot(m_arprot), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
  );

  // ---------------- clock / reset ----------------
  always #5 ACLK = ~ACLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int vectors = 0;
  int miscompares = 0;
  logic [0:0] exp_q[$];
  int c0_cnt = 0, c1_cnt = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Done monitor: counts pulses and checks grant order against exp_q while it is loaded.
  initial begin
    forever begin
      @(negedge ACLK);
      if (c0_done) c0_cnt++;
      if (c1_done) c1_cnt++;
      if ((c0_done || c1_done) && exp_q.size() > 0) check("grant", {63'd0, c1_done}, {63'd0, exp_q.pop_front()});
    end
  end

  // ---------------- slave model ----------------
  int aw_wait = 0, w_wait = 0, b_wait = 0, ar_wait = 0, r_wait = 0;
  int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
  logic [1:0]  r_resp_cfg = 2'b00;
  logic [31:0] mem [4];
  logic [3:0]  cap_awaddr, cap_araddr, cap_wstrb;
  logic [2:0]  cap_awprot;
  logic [31:0] cap_wdata;

  initial begin
    m_awready = 0; m_wready = 0; m_bvalid = 0; m_bresp = 0;
    m_arready = 0; m_rvalid = 0; m_rresp = 0; m_rdata = 0;
    aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
    cap_awaddr = 0; cap_araddr = 0; cap_wstrb = 0; cap_awprot = 0; cap_wdata = 0;
    for (int i = 0; i < 4; i++) mem[i] = 32'd0;
    forever begin
      @(negedge ACLK);
      if (ARESET) begin
        m_awready = 0; m_wready = 0; m_bvalid = 0; m_arready = 0; m_rvalid = 0;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
      end else begin
        if (m_awvalid) begin
          if (aw_cnt >= aw_wait) begin m_awready = 1; cap_awaddr = m_awaddr; cap_awprot = m_awprot; end
          else begin m_awready = 0; aw_cnt++; end
        end else begin m_awready = 0; aw_cnt = 0; end
        if (m_wvalid) begin
          if (w_cnt >= w_wait) begin m_wready = 1; cap_wdata = m_wdata; cap_wstrb = m_wstrb; end
          else begin m_wready = 0; w_cnt++; end
        end else begin m_wready = 0; w_cnt = 0; end
        if (m_bready) begin
          if (b_cnt >= b_wait) begin m_bvalid = 1; m_bresp = 2'b00; mem[cap_awaddr[3:2]] = cap_wdata; end
          else begin m_bvalid = 0; b_cnt++; end
        end else begin m_bvalid = 0; b_cnt = 0; end
        if (m_arvalid) begin
          if (ar_cnt >= ar_wait) begin m_arready = 1; cap_araddr = m_araddr; end
          else begin m_arready = 0; ar_cnt++; end
        end else begin m_arready = 0; ar_cnt = 0; end
        if (m_rready) begin
          if (r_cnt >= r_wait) begin m_rvalid = 1; m_rdata = mem[cap_araddr[3:2]]; m_rresp = r_resp_cfg; end
          else begin m_rvalid = 0; r_cnt++; end
        end else begin m_rvalid = 0; r_cnt = 0; end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_req(input bit cl, input bit we, input logic [3:0] addr, input logic [31:0] wd);
    if (!cl) begin c0_req = 1; c0_we = we; c0_addr = addr; c0_wdata = wd; end
    else     begin c1_req = 1; c1_we = we; c1_addr = addr; c1_wdata = wd; end
  endtask

  // Call at a falling edge; returns cycles until the client's done is seen, then drops req.
  task automatic wait_done(input bit cl, input int budget, output int n,
                           output logic [31:0] rd, output logic [1:0] rs);
    bit found = 0;
    n = 0; rd = 0; rs = 0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge ACLK);
      n++;
      if (cl ? c1_done : c0_done) begin found = 1; rd = rdata; rs = resp; end
    end
    if (!found) begin check("done_timeout", 64'd0, 64'd1); n = -1; end
    if (!cl) c0_req = 0; else c1_req = 0;
  endtask

  // ---------------- directed tests ----------------
  int n, g, base0, base1;
  logic [31:0] rd;
  logic [1:0]  rs;
  bit seen;

  initial begin
    ARESET = 1;
    c0_req = 0; c0_we = 0; c0_addr = 0; c0_wdata = 0;
    c1_req = 0; c1_we = 0; c1_addr = 0; c1_wdata = 0;
    repeat (2) @(negedge ACLK);
    check("rst_ctrl", {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, busy, c0_done, c1_done}, 64'd0);
    check("rst_data", {rdata, resp, m_awaddr, m_araddr}, 64'd0);
    check("rst_wdata", m_wdata, 64'd0);
    check("rst_state", dbg_state, 64'd0);
    ARESET = 0;

    // Single zero-wait write from c0.
    @(negedge ACLK);
    start_req(0, 1, 4'h4, 32'h5);
    wait_done(0, 20, n, rd, rs);
    check("wr_latency", n, 64'd3);
    check("wr_resp", rs, 64'd0);
    check("wr_awaddr", cap_awaddr, 64'h4);
    check("wr_wdata", cap_wdata, 64'h5);
    check("wr_wstrb", cap_wstrb, 64'hF);
    check("wr_awprot", cap_awprot, 64'd0);

    // c1 read-back with two wait cycles on AR and on R.
    ar_wait = 2; r_wait = 2;
    @(negedge ACLK);
    start_req(1, 0, 4'h4, 32'h0);
    wait_done(1, 30, n, rd, rs);
    check("rd_latency", n, 64'd7);
    check("rd_data", rd, 64'h5);
    check("rd_resp", rs, 64'd0);
    check("rd_araddr", cap_araddr, 64'h4);
    ar_wait = 0; r_wait = 0;

    // Contention: last grant was c1, so round-robin starts with c0.
`ifdef CNTR_ARB_RR_EN
    exp_q.push_back(1'b0); exp_q.push_back(1'b1); exp_q.push_back(1'b0); exp_q.push_back(1'b1);
`else
    repeat (4) exp_q.push_back(1'b0);
`endif
    @(negedge ACLK);
    start_req(0, 1, 4'h0, 32'h11);
    start_req(1, 1, 4'h8, 32'h22);
    g = 0;
    for (int i = 0; i < 60 && g < 4; i++) begin
      @(negedge ACLK);
      if (c0_done || c1_done) g++;
    end
    c0_req = 0; c1_req = 0;
    check("cont_grants", g, 64'd4);
    @(negedge ACLK);
    check("cont_exp_left", exp_q.size(), 64'd0);
    check("rdata_hold", rdata, 64'h5);

    // Split write: W handshake lags AW by three cycles; unaligned address gets masked.
    w_wait = 3;
    base0 = c0_cnt;
    @(negedge ACLK);
    start_req(0, 1, 4'hB, 32'h33);
    @(negedge ACLK);
    check("split_c1_valids", {m_awvalid, m_wvalid}, 64'h3);
    @(negedge ACLK);
    check("split_aw_drop", {m_awvalid, m_wvalid}, 64'h1);
    check("split_st_c2", dbg_state, 64'd1);
    repeat (2) @(negedge ACLK);
    check("split_st_c4", dbg_state, 64'd1);
    @(negedge ACLK);
    check("split_st_resp", dbg_state, 64'd2);
    wait_done(0, 20, n, rd, rs);
    check("split_done_lat", n, 64'd1);
    repeat (3) @(negedge ACLK);
    check("split_done_cnt", c0_cnt - base0, 64'd1);
    check("split_awaddr", cap_awaddr, 64'h8);
    check("split_wdata", cap_wdata, 64'h33);
    w_wait = 0;

    // SLVERR pass-through on a read.
    r_resp_cfg = 2'b10;
    @(negedge ACLK);
    start_req(0, 0, 4'hC, 32'h0);
    wait_done(0, 20, n, rd, rs);
    check("err_resp", rs, 64'h2);
    check("err_latency", n, 64'd3);
    @(negedge ACLK);
    check("err_idle", {dbg_state, busy}, 64'd0);
    r_resp_cfg = 2'b00;

    // Reset while waiting for the write response.
    b_wait = 5;
    base0 = c0_cnt; base1 = c1_cnt;
    @(negedge ACLK);
    start_req(0, 1, 4'h4, 32'h99);
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge ACLK);
      if (dbg_state == 3'd2) seen = 1;
    end
    check("rst_reach_wr_resp", seen, 64'd1);
    #2 ARESET = 1;
    #1;
    check("midrst_ctrl", {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, busy, c0_done, c1_done}, 64'd0);
    check("midrst_state", dbg_state, 64'd0);
    c0_req = 0;
    repeat (2) @(negedge ACLK);
    ARESET = 0;
    b_wait = 0;
    repeat (2) @(negedge ACLK);
    check("midrst_no_done", (c0_cnt - base0) + (c1_cnt - base1), 64'd0);
    check("midrst_idle", dbg_state, 64'd0);
    start_req(1, 0, 4'h4, 32'h0);
    wait_done(1, 20, n, rd, rs);
    check("post_rst_lat", n, 64'd3);
    check("post_rst_rd4", rd, 64'h5);
    @(negedge ACLK);
    start_req(0, 0, 4'h8, 32'h0);
    wait_done(0, 20, n, rd, rs);
    check("post_rst_rd8", rd, 64'h33);

    repeat (2) @(negedge ACLK);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
